// File: rtl/ysyx_22041412_encode.sv
// Field-to-word RV64IM encoder with immediate range check, buffered in a DEPTH-entry FIFO.
// Latency 1 (accept -> out_valid); in_ready drops only when the FIFO is full, no bypass.

// Generic circular FIFO with synchronous clear; pop_dat reads as zero while empty.
// Latency 1; push_rdy = !full, so a full FIFO never takes a push even alongside a pop.
module ysyx_22041412_encode_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_fire;
    logic             pop_fire;

    assign push_rdy  = (count_q != CW'(DEPTH));
    assign pop_vld   = (count_q != '0);
    assign pop_dat   = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign push_fire = push_vld & push_rdy & ~clr;
    assign pop_fire  = pop_vld & pop_rdy & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_fire) - CW'(pop_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through pop_dat, which is gated by pop_vld.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module ysyx_22041412_encode #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_func3,
    input  logic             in_f30,
    input  logic             in_f25,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [63:0]      in_imme,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        fit11, fit12, fit20, fit31;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic [32:0] head_dat;
    logic        pop_fire;

    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // An immediate fits in N+1 signed bits when every bit from N upward equals the sign.
    assign fit11 = (&in_imme[63:11]) | (~|in_imme[63:11]);
    assign fit12 = (&in_imme[63:12]) | (~|in_imme[63:12]);
    assign fit20 = (&in_imme[63:20]) | (~|in_imme[63:20]);
    assign fit31 = (&in_imme[63:31]) | (~|in_imme[63:31]);

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (in_opcode)
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
                enc_instr = {in_imme[11:0], in_rs1, in_func3, in_rd, in_opcode};
                enc_err   = ~fit11;
            end
            OP_LUI, OP_AUIPC: begin
                enc_instr = {in_imme[31:12], in_rd, in_opcode};
                enc_err   = ~fit31 | (|in_imme[11:0]);
            end
            OP_JAL: begin
                enc_instr = {in_imme[20], in_imme[10:1], in_imme[11], in_imme[19:12],
                             in_rd, in_opcode};
                enc_err   = ~fit20 | in_imme[0];
            end
            OP_BRANCH: begin
                enc_instr = {in_imme[12], in_imme[10:5], in_rs2, in_rs1, in_func3,
                             in_imme[4:1], in_imme[11], in_opcode};
                enc_err   = ~fit12 | in_imme[0];
            end
            OP_STORE: begin
                enc_instr = {in_imme[11:5], in_rs2, in_rs1, in_func3, in_imme[4:0], in_opcode};
                enc_err   = ~fit11;
            end
            OP_OP, OP_OP32: begin
                enc_instr = {1'b0, in_f30, 4'b0000, in_f25, in_rs2, in_rs1, in_func3,
                             in_rd, in_opcode};
            end
            OP_SYSTEM: enc_instr = 32'h0010_0073;
            default:   enc_err   = 1'b1;
        endcase
    end

    ysyx_22041412_encode_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({enc_err, enc_instr}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign out_err   = head_dat[32];
    assign out_instr = head_dat[31:0];
    assign pop_fire  = out_valid & out_ready & ~flush;

    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (pop_fire) begin
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
            if (out_err) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign enc_cnt = enc_cnt_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_ysyx_22041412_encode.sv
// Randomized bench for the field encoder against an arithmetic reference model and scoreboard.
module tb_ysyx_22041412_encode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_func3 = '0;
    logic        in_f30 = 1'b0;
    logic        in_f25 = 1'b0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic [63:0] in_imme = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] enc_cnt;
    logic [31:0] err_cnt;

    always #5 clk = ~clk;

    ysyx_22041412_encode #(.DEPTH(2), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_func3  (in_func3),
        .in_f30    (in_f30),
        .in_f25    (in_f25),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_imme   (in_imme),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_enc = '0;
    logic [31:0] m_err = '0;

    // Reference: place each field by shift/mask, judge encodability as a signed range test.
    function automatic exp_t ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                     input logic f30, input logic f25,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [63:0] imm);
        longint      v;
        logic [63:0] w;
        logic [63:0] base;
        logic        e;
        exp_t        r;
        v    = $signed(imm);
        base = 64'(op) | (64'(rd) << 7) | (64'(f3) << 12) | (64'(rs1) << 15) | (64'(rs2) << 20);
        w    = 64'd0;
        e    = 1'b0;
        case (op)
            7'b0010011, 7'b0000011, 7'b0011011, 7'b1100111: begin
                w = (64'(op) | (64'(rd) << 7) | (64'(f3) << 12) | (64'(rs1) << 15))
                    | ((imm & 64'hFFF) << 20);
                e = (v < -2048) || (v > 2047);
            end
            7'b0100011: begin
                w = (base & ~(64'h1F << 7)) | ((imm & 64'h1F) << 7) | (((imm >> 5) & 64'h7F) << 25);
                e = (v < -2048) || (v > 2047);
            end
            7'b1100011: begin
                w = (base & ~(64'h1F << 7)) | (((imm >> 11) & 64'h1) << 7)
                    | (((imm >> 1) & 64'hF) << 8) | (((imm >> 5) & 64'h3F) << 25)
                    | (((imm >> 12) & 64'h1) << 31);
                e = (v < -4096) || (v > 4095) || ((v % 2) != 0);
            end
            7'b1101111: begin
                w = 64'(op) | (64'(rd) << 7) | (((imm >> 12) & 64'hFF) << 12)
                    | (((imm >> 11) & 64'h1) << 20) | (((imm >> 1) & 64'h3FF) << 21)
                    | (((imm >> 20) & 64'h1) << 31);
                e = (v < -1048576) || (v > 1048575) || ((v % 2) != 0);
            end
            7'b0110111, 7'b0010111: begin
                w = 64'(op) | (64'(rd) << 7) | (imm & 64'hFFFF_F000);
                e = (v < -64'sd2147483648) || (v > 64'sd2147483647) || ((imm & 64'hFFF) != 0);
            end
            7'b0110011, 7'b0111011: begin
                w = base | (64'(f30) << 30) | (64'(f25) << 25);
            end
            7'b1110011: w = 64'h0010_0073;
            default:    e = 1'b1;
        endcase
        r.instr = w[31:0];
        r.err   = e;
        return r;
    endfunction

    // Scoreboard: the queue mirrors FIFO contents between edges.
    always @(negedge clk) begin
        exp_t f;
        if (!rst_n) begin
            exp_q.delete();
            m_enc = '0;
            m_err = '0;
        end else begin
            chk("enc_cnt", enc_cnt, m_enc);
            chk("err_cnt", err_cnt, m_err);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                f = exp_q[0];
                chk("head_instr", out_instr, f.instr);
                chk("head_err", out_err, f.err);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    m_enc = m_enc + 1;
                    if (f.err) m_err = m_err + 1;
                end
                if (in_valid && in_ready)
                    exp_q.push_back(ref_enc(in_opcode, in_func3, in_f30, in_f25,
                                            in_rs1, in_rs2, in_rd, in_imme));
            end
        end
    end

    logic [6:0]  ops [12] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0011011, 7'b0100011,
                              7'b0110011, 7'b0110111, 7'b0111011, 7'b1100011, 7'b1100111,
                              7'b1101111, 7'b1110011};
    logic [63:0] bnd [14] = '{64'd2047, 64'd2048, -64'd2048, -64'd2049, 64'd4094, 64'd4095,
                              -64'd4096, -64'd4098, 64'd1048574, 64'd1048576, -64'd1048576,
                              64'h7FFF_F000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000};

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic f30,
                              input logic f25, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [63:0] imm);
        in_opcode = op; in_func3 = f3; in_f30 = f30; in_f25 = f25;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imme = imm;
    endtask

    task automatic set_rand();
        int k;
        int c;
        logic [63:0] imm;
        k = $urandom_range(0, 12);
        c = $urandom_range(0, 3);
        if (c == 0)      imm = 64'($signed($urandom_range(0, 64)) - 32);
        else if (c == 1) imm = bnd[$urandom_range(0, 13)];
        else if (c == 2) imm = {{32{1'b0}}, $urandom()} & 64'hFFFF_F000;
        else             imm = {$urandom(), $urandom()};
        set_fields((k == 12) ? 7'($urandom()) : ops[k], 3'($urandom()), 1'($urandom()),
                   1'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), imm);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push_cur();
        bit acc = 0;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1; break; end
        end
        if (!acc) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_rand();
        set_rand();
        push_cur();
    endtask

    task automatic directed(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f25, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [63:0] imm,
                            input logic [31:0] exp_w, input logic exp_e);
        set_fields(op, f3, 1'b0, f25, rs1, rs2, rd, imm);
        push_cur();
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_instr"}, out_instr, exp_w);
        chk({tag, "_err"}, out_err, exp_e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        chk("drain", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit acc;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_err", out_err, 0);
        chk("rst_enc_cnt", enc_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        directed("addi", 7'b0010011, 3'd0, 1'b0, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF1_0093, 1'b0);
        directed("jal",  7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 64'd8, 32'h0080_00EF, 1'b0);
        directed("beq",  7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, -64'd4, 32'hFE20_8EE3, 1'b0);
        directed("sd",   7'b0100011, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 64'd8, 32'h0020_B423, 1'b0);
        directed("mul",  7'b0110011, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 64'd0, 32'h0220_81B3, 1'b0);
        directed("lui",  7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 64'h1234_5000, 32'h1234_52B7, 1'b0);
        directed("ebreak", 7'b1110011, 3'd5, 1'b1, 5'd9, 5'd7, 5'd4, 64'h55, 32'h0010_0073, 1'b0);
        directed("addi_big", 7'b0010011, 3'd0, 1'b0, 5'd2, 5'd0, 5'd1, 64'd2048, 32'h8001_0093, 1'b1);
        @(negedge clk);
        chk("err_cnt_first", err_cnt, 1);
        @(posedge clk); #1;
        directed("beq_odd", 7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 64'd3, 32'h0020_8163, 1'b1);
        directed("bad_op", 7'h7F, 3'd1, 1'b0, 5'd1, 5'd2, 5'd3, 64'd0, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("enc_cnt_dir", enc_cnt, 10);
        chk("err_cnt_dir", err_cnt, 3);
        @(posedge clk); #1;

        // Asynchronous reset with two words queued.
        out_ready = 1'b0;
        push_rand();
        push_rand();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_enc_cnt", enc_cnt, 0);
        chk("mrst_err_cnt", err_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Backpressure: third push must stall until a pop frees space.
        set_rand(); in_valid = 1'b1;
        @(negedge clk); chk("bp_rdy0", in_ready, 1);
        @(posedge clk); #1; set_rand();
        @(negedge clk); chk("bp_rdy1", in_ready, 1);
        @(posedge clk); #1; set_rand();
        @(negedge clk); chk("bp_full", in_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); chk("bp_held", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        acc = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1; break; end
        end
        chk("bp_third_accept", acc, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        chk("bp_enc_cnt", enc_cnt, 3);

        // Stall/release every cycle while 16 random words stream through.
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                out_ready = ~out_ready;
            end
            for (int n = 0; n < 16; n++) push_rand();
        join
        out_ready = 1'b1;
        drain();
        chk("hold_q_empty", exp_q.size(), 0);
        chk("hold_enc_cnt", enc_cnt, 19);

        // Flush with one queued word and a concurrent (dropped) push.
        out_ready = 1'b0;
        push_rand();
        set_rand(); flush = 1'b1; in_valid = 1'b1;
        @(negedge clk); chk("fl1_in_ready", in_ready, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl1_valid", out_valid, 0);
        chk("fl1_enc_cnt", enc_cnt, 19);
        @(posedge clk); #1;

        // Flush with a full FIFO, a pending push and a pop attempt.
        push_rand();
        push_rand();
        set_rand(); flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("fl2_valid", out_valid, 0);
        chk("fl2_enc_cnt", enc_cnt, 19);
        @(posedge clk); #1;

        // Random soak with random consumer stalls.
        fork
            for (int i = 0; i < 900; i++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            for (int n = 0; n < 200; n++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                push_rand();
            end
        join
        out_ready = 1'b1;
        drain();
        chk("soak_q_empty", exp_q.size(), 0);
        chk("soak_enc_cnt", enc_cnt, m_enc);
        chk("soak_err_cnt", err_cnt, m_err);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_encode.md
Name: ysyx_22041412_encode

Overview:
Inverse of the ysyx_22041412 instruction decoder. It takes decoded fields and packs them into a 32-bit RV64IM instruction word: opcode, func3, bit30 and bit25 of func7, rs1, rs2, rd and a 64-bit sign-extended immediate. It checks that the immediate is encodable and buffers results in a small output FIFO with valid/ready handshakes on both sides. It is used by the self-test instruction generator and by the difftest stimulus path, which feeds words back into fetch/decode.

Parameters:
DEPTH, 2, output FIFO entries; power of two, ≥2.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of FIFO contents. Counters are kept.
in_valid  in  1  field bundle valid.
in_ready  out  1  encoder can accept; equals !full.
in_opcode  in  7  instr[6:0].
in_func3  in  3  instr[14:12].
in_f30  in  1  instr[30] for R-type.
in_f25  in  1  instr[25] for R-type (M-extension select).
in_rs1  in  5  source register 1.
in_rs2  in  5  source register 2.
in_rd  in  5  destination register.
in_imme  in  64  sign-extended immediate, same format the decoder produces.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_instr  out  32  encoded word at head.
out_err  out  1  head was flagged unencodable.
enc_cnt  out  CNT_W  words delivered.
err_cnt  out  CNT_W  delivered words with err=1.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_cnt=0, err_cnt=0, in_ready=1 one cycle after release.
- Accept on in_valid&in_ready. The word is encoded combinationally and written to the FIFO tail in the same edge. out_valid rises the next cycle (latency 1). Throughput is 1 word/cycle.
- Push and pop in the same cycle while full is not allowed, because in_ready=0 when full. No bypass path.
- Pop on out_valid&out_ready. out_instr/out_err show the head; they must hold stable while out_valid=1 and out_ready=0.
- Counters: on each pop, enc_cnt+1; err_cnt+1 when out_err=1. Both wrap modulo 2^CNT_W.
- flush: count=0, pointers reset, out_valid=0 next cycle. A same-cycle push is dropped and a same-cycle pop is not counted.
- Common fields: [6:0]=opcode, [11:7]=rd, [14:12]=func3, [19:15]=rs1, [24:20]=rs2. Each is used only where the format has that field.
- Format by opcode:
  - jalr 1100111, load 0000011, OP-IMM 0010011, OP-IMM-32 0011011 (I): [31:20]=imme[11:0].
  - lui 0110111, auipc 0010111 (U): [31:12]=imme[31:12].
  - jal 1101111 (J): [31]=imme[20], [30:21]=imme[10:1], [20]=imme[11], [19:12]=imme[19:12].
  - branch 1100011 (B): [31]=imme[12], [30:25]=imme[10:5], [11:8]=imme[4:1], [7]=imme[11].
  - store 0100011 (S): [31:25]=imme[11:5], [11:7]=imme[4:0].
  - OP 0110011, OP-32 0111011 (R): [31:25]={0,in_f30,0000,in_f25}.
  - SYSTEM 1110011: fixed 0x00100073 (ebreak); other fields ignored.
- Shifts in I format encode imme[11:0] verbatim, so the caller places the func7 bits in the immediate.
- Error rules (err=1; word is still encoded with truncated fields):
  - I/S: imme[63:11] not all equal.
  - B: imme[63:12] not all equal, or imme[0]=1.
  - J: imme[63:20] not all equal, or imme[0]=1.
  - U: imme[63:31] not all equal, or imme[11:0]≠0.
  - Unknown opcode: err=1, instr=0x00000000.

Test Plan:
- Reset mid-stream with 2 entries queued: assert rst_n=0 → out_valid=0, counters=0 immediately; in_ready=1 after release.
- Formats: each of the following with out_ready=1 → exact word one cycle later, err=0.
  - addi x1,x2,-1 (op 0010011, f3 0, imme 0xFFFF_FFFF_FFFF_FFFF) → 0xFFF10093.
  - jal x1,+8 → 0x008000EF.
  - beq x1,x2,-4 → 0xFE208EE3.
  - sd x2,8(x1) → 0x0020B423.
  - mul x3,x1,x2 (f25=1) → 0x022081B3.
  - lui x5,imme 0x12345000 → 0x123452B7.
  - opcode 1110011 → 0x00100073.
- Errors:
  - addi with imme=2048 → err=1, err_cnt=1 after pop.
  - beq with imme=3 → err=1.
  - opcode 0x7F → instr 0, err=1.
- Backpressure, DEPTH=2, out_ready=0, 3 back-to-back pushes → in_ready=0 after the 2nd accept; 3rd held. Then out_ready=1 → words pop in order, 3rd accepted; enc_cnt=3.
- Hold stability: out_ready toggled 0/1 every cycle → out_instr unchanged while stalled; no loss or duplication over 16 random words.
- flush with 2 entries queued plus a simultaneous push → out_valid=0 next cycle; enc_cnt unchanged.
